// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped bus timer: register offsets,
// control/status bit positions and the default window base address.
package timer_pkg;

    localparam logic [15:0] BASE_DEFAULT = 16'hFF00;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_STATUS   = 3'd1;
    localparam logic [2:0] OFF_RELOAD_H = 3'd2;
    localparam logic [2:0] OFF_RELOAD_L = 3'd3;
    localparam logic [2:0] OFF_COUNT_H  = 3'd4;
    localparam logic [2:0] OFF_COUNT_L  = 3'd5;
    localparam logic [2:0] OFF_PRESCALE = 3'd6;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_IE    = 2;
    localparam int STATUS_EXP = 0;
    localparam int STATUS_RUN = 1;

endpackage

// File: rtl/timer_prescaler.sv
// 8-bit prescaler: counts while enabled and emits a one-clock tick when it
// reaches div, then wraps to zero. A clear cancels any tick in that cycle.
module timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick = en && !clr && (cnt_q == div);

    // next prescaler count
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            if (cnt_q == div) begin
                cnt_d = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // prescaler count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// 16-bit down-counting timer on an 8-bit shared CPU bus with one-shot or
// auto-reload expiry, coherent two-byte count read and a low interrupt pulse.
module bus_timer
    import timer_pkg::*;
#(
    parameter logic [15:0] BASE      = BASE_DEFAULT,
    parameter int          IRQ_PULSE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    inout  wire  [7:0]  data,
    input  logic        re,
    input  logic        we,
    output logic        interrupt
);

    localparam logic [2:0] PULSE_LEN = IRQ_PULSE[2:0];

    logic [2:0]  ctrl_q,   ctrl_d;
    logic        exp_q,    exp_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q,  count_d;
    logic [7:0]  stage_q,  stage_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [7:0]  presc_q,  presc_d;
    logic [2:0]  pulse_q,  pulse_d;
    logic        irq_n_q;

    logic        sel_s;
    logic [2:0]  off_s;
    logic        wr_s;
    logic        tick_s;
    logic        expire_s;
    logic [7:0]  rdata_s;

    assign sel_s    = (addr[15:3] == BASE[15:3]);
    assign off_s    = addr[2:0];
    assign wr_s     = we && sel_s && !re;
    assign expire_s = tick_s && (count_q == 16'd0);

    timer_prescaler u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (ctrl_q[CTRL_EN]),
        .clr  (wr_s && (off_s == OFF_COUNT_L)),
        .div  (presc_q),
        .tick (tick_s)
    );

    // next state: tick effects first (using pre-write CTRL), then CPU writes override
    always_comb begin
        ctrl_d   = ctrl_q;
        exp_d    = exp_q;
        reload_d = reload_q;
        count_d  = count_q;
        stage_d  = stage_q;
        shadow_d = shadow_q;
        presc_d  = presc_q;
        pulse_d  = pulse_q;

        if (tick_s) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else if (ctrl_q[CTRL_AUTO]) begin
                count_d = reload_q;
            end else begin
                ctrl_d[CTRL_EN] = 1'b0;
            end
        end else begin
            count_d = count_q;
        end

        if (wr_s) begin
            case (off_s)
                OFF_CTRL:     ctrl_d          = data[2:0];
                OFF_STATUS:   exp_d           = exp_q && !data[STATUS_EXP];
                OFF_RELOAD_H: reload_d[15:8]  = data;
                OFF_RELOAD_L: reload_d[7:0]   = data;
                OFF_COUNT_H:  stage_d         = data;
                OFF_COUNT_L:  count_d         = {stage_q, data};
                OFF_PRESCALE: presc_d         = data;
                default:      ;
            endcase
        end else begin
            stage_d = stage_q;
        end

        // a same-cycle expiry beats a software clear
        exp_d = exp_d || expire_s;

        if (re && (addr == {BASE[15:3], OFF_COUNT_H})) begin
            shadow_d = count_q[7:0];
        end else begin
            shadow_d = shadow_q;
        end

        if (pulse_q != 3'd0) begin
            pulse_d = pulse_q - 3'd1;
        end else if (expire_s && ctrl_q[CTRL_IE]) begin
            pulse_d = PULSE_LEN;
        end else begin
            pulse_d = 3'd0;
        end
    end

    // register read multiplexer
    always_comb begin
        rdata_s = 8'h00;
        case (off_s)
            OFF_CTRL:     rdata_s = {5'b00000, ctrl_q};
            OFF_STATUS:   rdata_s = {6'b000000, ctrl_q[CTRL_EN], exp_q};
            OFF_RELOAD_H: rdata_s = reload_q[15:8];
            OFF_RELOAD_L: rdata_s = reload_q[7:0];
            OFF_COUNT_H:  rdata_s = count_q[15:8];
            OFF_COUNT_L:  rdata_s = shadow_q;
            OFF_PRESCALE: rdata_s = presc_q;
            default:      rdata_s = 8'h00;
        endcase
    end

    assign data      = (rst && sel_s && re) ? rdata_s : 8'hzz;
    assign interrupt = irq_n_q;

    // state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q   <= 3'd0;
            exp_q    <= 1'b0;
            reload_q <= 16'd0;
            count_q  <= 16'd0;
            stage_q  <= 8'd0;
            shadow_q <= 8'd0;
            presc_q  <= 8'd0;
            pulse_q  <= 3'd0;
            irq_n_q  <= 1'b1;
        end else begin
            ctrl_q   <= ctrl_d;
            exp_q    <= exp_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            stage_q  <= stage_d;
            shadow_q <= shadow_d;
            presc_q  <= presc_d;
            pulse_q  <= pulse_d;
            irq_n_q  <= (pulse_d == 3'd0);
        end
    end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameter BASE, default 16'hFF00, start address of the 8-byte register window (BASE[2:0] SHALL be 0).
REQ-002 Parameter IRQ_PULSE, default 4, interrupt low-pulse length in clocks (1..7).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 addr  input  16  CPU address, changes on rising clk.
REQ-006 data  inout  8  shared CPU data bus.
REQ-007 re  input  1  1 = CPU reading (CPU releases data); 0 = CPU driving data.
REQ-008 we  input  1  write strobe, high for exactly one full clock period (falling edge to falling edge).
REQ-009 interrupt  output  1  idle high; active-low pulse, consumed on its falling edge.

Function
REQ-010 sel SHALL be true when addr[15:3] == BASE[15:3]; off = addr[2:0].
REQ-011 data SHALL be driven combinationally only when sel && re; otherwise hi-Z.
REQ-012 Register map: 0 CTRL (bit0 EN, bit1 AUTO, bit2 IE); 1 STATUS (bit0 EXP, bit1 RUN = EN); 2 RELOAD_H; 3 RELOAD_L; 4 COUNT_H; 5 COUNT_L; 6 PRESCALE; 7 reads 8'h00; unused bits read 0.
REQ-013 Write SHALL be captured at the single rising edge with we && sel && !re; writes to 7 are ignored.
REQ-014 STATUS write: EXP cleared where data bit0 = 1; RUN is read-only.
REQ-015 COUNT_H write loads an 8-bit staging register; COUNT_L write loads count = {staging, data} and clears the prescaler.
REQ-016 COUNT_H read returns count[15:8]; at every rising edge with re && addr == BASE+4, count[7:0] is copied into shadow_lo; COUNT_L read returns shadow_lo (coherent 16-bit read, high byte first).
REQ-017 Prescaler: 8-bit counter, runs only while EN; issues tick and returns to 0 when it equals PRESCALE; PRESCALE = 0 gives a tick every clock.
REQ-018 On tick with count != 0: count decrements by 1.
REQ-019 On tick with count == 0: EXP set; if AUTO, count = reload; else count stays 0 and EN clears (one-shot).
REQ-020 Expiry with IE = 1 SHALL drive interrupt low starting the next rising edge, for exactly IRQ_PULSE clocks, then high.
REQ-021 Expiry during an active pulse: EXP set, pulse neither extended nor restarted.
REQ-022 Same-cycle STATUS clear and expiry: EXP ends set.
REQ-023 Same-cycle COUNT_L write and tick: the write wins and no decrement occurs.
REQ-024 Same-cycle CTRL write and tick: the tick uses pre-write CTRL; new CTRL applies from the next edge.
REQ-025 Clearing EN freezes count and the prescaler; setting EN resumes from the held values.
REQ-026 Writing RELOAD_H/L does not affect the current count.

Reset
REQ-027 rst low SHALL immediately force: CTRL, STATUS, reload, count, staging, shadow_lo, PRESCALE, prescaler, pulse counter = 0; interrupt = 1; data hi-Z.
REQ-028 Reset asserted mid-pulse SHALL return interrupt high without waiting for a clock.
REQ-029 First write is accepted at the first qualifying rising edge after rst deasserts.

Structure
REQ-030 Shared package timer_pkg holds the register offsets (OFF_CTRL..OFF_PRESCALE), the CTRL/STATUS bit indices and the default BASE.
REQ-031 The prescaler SHALL be a sub-module timer_prescaler (ports clk, rst, en, clr, div[7:0], tick).
REQ-032 All other logic is in bus_timer; one tri-state driver for data.

Verification
REQ-033 Reset: rst low mid-count with interrupt low -> interrupt = 1 and all eight registers read 8'h00 after release.
REQ-034 One-shot: PRESCALE = 0, COUNT = 16'h0003, CTRL = 8'h05 -> EXP set on the 4th tick, interrupt low for 4 clocks, EN = 0, count stays 0.
REQ-035 Auto-reload: RELOAD = 16'h0002, PRESCALE = 8'h01, CTRL = 8'h07 -> expiry every 6 clocks, count sequence 2,1,0,2,...
REQ-036 Coherent read: count = 16'h0100, reading COUNT_H then COUNT_L across a decrement -> returns 8'h01, 8'h00 (shadow), not 8'h00/8'hFF.
REQ-037 Collision: STATUS write 8'h01 in the expiry cycle -> EXP reads 1; a separate clear later -> EXP reads 0.
REQ-038 Bus isolation: addr = BASE-1 and addr = BASE+8 with re = 1 -> data hi-Z; a write with re = 1 -> ignored.
